data_memory_arbiter: RTL and testbench

Shares the single-port data memory between two requesters: port 0, the pipeline MEM stage, which has priority, and port 1, a debug/DMA master. Each access is granted through a req/ack handshake and sequenced by a three-state FSM. Each access is driven to the memory for exactly one cycle, and the read data is registered back to the winner. The block sits between the requesters and the data memory and owns that memory's address, write-enable and write-data pins.

---
 rtl/data_memory_arbiter_pkg.sv | 26 ++
 rtl/data_memory_arbiter_if.sv | 37 +++
 rtl/data_memory_arbiter_starvation_counter.sv | 38 +++
 rtl/data_memory_arbiter.sv | 121 ++++++++++++
 tb/tb_data_memory_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and constants for the data memory arbiter: word type, FSM encoding,
// per-port request bundle and the default address limit.
package data_memory_arbiter_pkg;

    typedef logic [31:0] int_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    typedef struct packed {
        int_t address;
        logic writeEnabled;
        int_t dataWrite;
    } arb_port_t;

    // First byte address past the 1024-word data memory.
    localparam int_t DM_ADDR_LIMIT = 32'h0000_1000;

    function automatic logic out_of_range(input int_t addr, input int_t limit);
        return addr >= limit;
    endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Requester handshakes plus data-memory pins of the arbiter, with the arbiter side
// (slave) and the requester/memory side (master) as modports.
interface data_memory_arbiter_if;
    import data_memory_arbiter_pkg::*;

    logic req0;
    logic req1;
    int_t address0;
    int_t address1;
    logic writeEnabled0;
    logic writeEnabled1;
    int_t dataWrite0;
    int_t dataWrite1;
    logic ack0;
    logic ack1;
    int_t dataRead;
    logic accessError;
    int_t memAddress;
    logic memWriteEnabled;
    int_t memDataWrite;
    int_t memDataRead;

    modport slave (
        input  req0, req1, address0, address1, writeEnabled0, writeEnabled1,
        input  dataWrite0, dataWrite1, memDataRead,
        output ack0, ack1, dataRead, accessError,
        output memAddress, memWriteEnabled, memDataWrite
    );

    modport master (
        output req0, req1, address0, address1, writeEnabled0, writeEnabled1,
        output dataWrite0, dataWrite1, memDataRead,
        input  ack0, ack1, dataRead, accessError,
        input  memAddress, memWriteEnabled, memDataWrite
    );

endinterface

// File: rtl/data_memory_arbiter_starvation_counter.sv
// Counts cycles port 1 waits with its request up; once saturated at STARVE_LIMIT it
// asks the arbiter to let port 1 win an idle-state tie. Cleared when port 1 is granted.
module arbiter_starvation_counter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic resetN,
    input  logic req1,
    input  logic port1_busy,
    input  logic port1_enter,
    output logic prefer1
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0] wait_count_q;
    logic [2:0] wait_count_d;

    always_comb begin
        wait_count_d = wait_count_q;
        if (port1_enter) begin
            wait_count_d = 3'd0;
        end else if (req1 && !port1_busy && (wait_count_q != LIMIT)) begin
            wait_count_d = wait_count_q + 3'd1;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wait_count_q <= 3'd0;
        end else begin
            wait_count_q <= wait_count_d;
        end
    end

    assign prefer1 = (wait_count_q == LIMIT);

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter for the single-port data memory; port 0 has priority, the port that
// did not just finish wins next. Request to ack is 2 cycles; requesters hold req until ack.
// Optional starvation guard: DATA_MEMORY_ARBITER_STARVATION_GUARD_EN.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int   STARVE_LIMIT = 4,
    parameter int_t ADDR_LIMIT   = DM_ADDR_LIMIT
) (
    input logic clock,
    input logic resetN,
    data_memory_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SERVE = SERVE;
    localparam logic [1:0] ST_DONE  = DONE;

    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 7)) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must fit the 3-bit wait counter (1..7)");
    end

    logic [1:0] state_q, state_d;
    logic       owner_q, owner_d;
    int_t       data_read_q, data_read_d;
    logic       access_error_q, access_error_d;

    arb_port_t  port0, port1, own;
    logic       own_oor;
    logic       other_req;
    logic       prefer1;

    assign port0 = '{address: bus.address0, writeEnabled: bus.writeEnabled0, dataWrite: bus.dataWrite0};
    assign port1 = '{address: bus.address1, writeEnabled: bus.writeEnabled1, dataWrite: bus.dataWrite1};
    assign own       = owner_q ? port1 : port0;
    assign own_oor   = out_of_range(own.address, ADDR_LIMIT);
    assign other_req = owner_q ? bus.req0 : bus.req1;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        data_read_d    = data_read_q;
        access_error_d = access_error_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    owner_d = bus.req1 && (!bus.req0 || prefer1);
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                data_read_d    = own_oor ? 32'h0 : bus.memDataRead;
                access_error_d = own_oor;
                state_d        = ST_DONE;
            end
            ST_DONE: begin
                // The owner still holds its req here, so only the other port can follow.
                if (other_req) begin
                    owner_d = !owner_q;
                    state_d = ST_SERVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q        <= ST_IDLE;
            owner_q        <= 1'b0;
            data_read_q    <= 32'h0;
            access_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            data_read_q    <= data_read_d;
            access_error_q <= access_error_d;
        end
    end

`ifdef DATA_MEMORY_ARBITER_STARVATION_GUARD_EN
    logic port1_busy;
    logic port1_enter;

    assign port1_busy  = owner_q && ((state_q == ST_SERVE) || (state_q == ST_DONE));
    assign port1_enter = owner_d && (state_d == ST_SERVE);

    arbiter_starvation_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starvation_counter (
        .clock       (clock),
        .resetN      (resetN),
        .req1        (bus.req1),
        .port1_busy  (port1_busy),
        .port1_enter (port1_enter),
        .prefer1     (prefer1)
    );
`else
    assign prefer1 = 1'b0;
`endif

    // Memory pins are decoded from state so a reset in SERVE kills the write at once.
    assign bus.memAddress      = (state_q == ST_SERVE) ? own.address : 32'h0;
    assign bus.memDataWrite    = (state_q == ST_SERVE) ? own.dataWrite : 32'h0;
    assign bus.memWriteEnabled = (state_q == ST_SERVE) && own.writeEnabled && !own_oor;

    assign bus.ack0        = (state_q == ST_DONE) && !owner_q;
    assign bus.ack1        = (state_q == ST_DONE) && owner_q;
    assign bus.dataRead    = data_read_q;
    assign bus.accessError = access_error_q;

    a_req0_held: assert property (@(posedge clock) disable iff (!resetN)
        (bus.req0 && !bus.ack0) |=> (bus.req0 || bus.ack0));
    a_req1_held: assert property (@(posedge clock) disable iff (!resetN)
        (bus.req1 && !bus.ack1) |=> (bus.req1 || bus.ack1));

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: vector table of single accesses plus hand-written
// contention, starvation and mid-access reset sequences, checked through per-port queues.
module tb_data_memory_arbiter;

    logic clock = 1'b0;
    logic resetN = 1'b0;
    always #5 clock = ~clock;

    data_memory_arbiter_if bus ();

    data_memory_arbiter u_dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    logic [31:0] mem [0:1023];
    assign bus.memDataRead = mem[bus.memAddress[11:2]];
    always @(posedge clock) begin
        if (bus.memWriteEnabled) mem[bus.memAddress[11:2]] <= bus.memDataWrite;
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   oor_writes = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_ack(input int port);
        exp_t e;
        if ((port == 0 && q0.size() == 0) || (port == 1 && q1.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ack%0d: ack with no outstanding request", port);
        end else begin
            e = (port == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("dataRead_port%0d", port), 128'(bus.dataRead), 128'(e.data));
            check($sformatf("accessError_port%0d", port), 128'(bus.accessError), 128'(e.err));
        end
    endtask

    always @(negedge clock) begin
        if (bus.memWriteEnabled && (bus.memAddress >= 32'h1000)) oor_writes++;
        if (bus.ack0 && bus.ack1) check("dual_ack", 128'(1), 128'(0));
        if (bus.ack0) check_ack(0);
        if (bus.ack1) check_ack(1);
    end

    // Called at a falling edge; raises req, waits for the ack, drops req in the ack cycle.
    task automatic run_access(input int port, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_data,
                              input logic exp_err, input int exp_lat, input string name);
        exp_t e;
        int   lat = 0;
        e.data = exp_data;
        e.err  = exp_err;
        if (port == 0) begin
            bus.address0 = addr; bus.writeEnabled0 = we; bus.dataWrite0 = wdata;
            q0.push_back(e);
            bus.req0 = 1'b1;
        end else begin
            bus.address1 = addr; bus.writeEnabled1 = we; bus.dataWrite1 = wdata;
            q1.push_back(e);
            bus.req1 = 1'b1;
        end
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            @(negedge clock);
            if ((port == 0) ? bus.ack0 : bus.ack1) lat = c;
        end
        if (lat == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no ack within 12 cycles", name);
        end else begin
            check({name, "_latency"}, 128'(lat), 128'(exp_lat));
        end
        if (port == 0) bus.req0 = 1'b0;
        else           bus.req1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs [9];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
        mem[4] = 32'hDEAD_BEEF;

        vecs[0] = '{0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 2};
        vecs[1] = '{0, 1'b0, 32'h0000_0014, 32'h0,         32'hA000_0005, 1'b0, 3};
        vecs[2] = '{1, 1'b1, 32'h0000_0024, 32'h1234_5678, 32'hA000_0009, 1'b0, 2};
        vecs[3] = '{0, 1'b0, 32'h0000_0024, 32'h0,         32'h1234_5678, 1'b0, 2};
        vecs[4] = '{1, 1'b1, 32'h0000_1000, 32'h0000_0055, 32'h0,         1'b1, 2};
        vecs[5] = '{0, 1'b0, 32'h0000_0000, 32'h0,         32'hA000_0000, 1'b0, 2};
        vecs[6] = '{1, 1'b0, 32'h0000_0FFC, 32'h0,         32'hA000_03FF, 1'b0, 2};
        vecs[7] = '{0, 1'b0, 32'h2000_0000, 32'h0,         32'h0,         1'b1, 2};
        vecs[8] = '{0, 1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0, 3};

        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.address0 = '0; bus.address1 = '0;
        bus.writeEnabled0 = 1'b0; bus.writeEnabled1 = 1'b0;
        bus.dataWrite0 = '0; bus.dataWrite1 = '0;

        repeat (2) @(negedge clock);
        check("reset_acks", 128'({bus.ack0, bus.ack1}), 128'(0));
        check("reset_dataRead", 128'(bus.dataRead), 128'(0));
        check("reset_accessError", 128'(bus.accessError), 128'(0));
        check("reset_memWriteEnabled", 128'(bus.memWriteEnabled), 128'(0));
        check("reset_memAddress", 128'(bus.memAddress), 128'(0));
        check("reset_memDataWrite", 128'(bus.memDataWrite), 128'(0));
        resetN = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                       vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat,
                       $sformatf("vec%0d", i));
        end
        check("oor_store_mem0", 128'(mem[0]), 128'(32'hA000_0000));
        repeat (2) @(negedge clock);

        // Same-cycle store on port 0 and load of that word on port 1.
        fork
            run_access(0, 1'b1, 32'h20, 32'h11, 32'hA000_0008, 1'b0, 2, "simul_p0");
            run_access(1, 1'b0, 32'h20, 32'h0,  32'h0000_0011, 1'b0, 4, "simul_p1");
        join
        repeat (2) @(negedge clock);

        // Port 0 keeps re-requesting while port 1 waits.
        fork
            begin
                run_access(0, 1'b0, 32'h34, 32'h0, 32'hA000_000D, 1'b0, 2, "starve_p0a");
                run_access(0, 1'b0, 32'h38, 32'h0, 32'hA000_000E, 1'b0, 4, "starve_p0b");
            end
            run_access(1, 1'b0, 32'h30, 32'h0, 32'hA000_000C, 1'b0, 4, "starve_p1");
        join
        repeat (2) @(negedge clock);

        // Reset arriving while a store is in SERVE.
        bus.address0 = 32'h40; bus.writeEnabled0 = 1'b1; bus.dataWrite0 = 32'h77;
        bus.req0 = 1'b1;
        @(negedge clock);
        check("rst_serve_we", 128'(bus.memWriteEnabled), 128'(1));
        check("rst_serve_addr", 128'(bus.memAddress), 128'(32'h40));
        resetN = 1'b0;
        #1;
        check("rst_mid_we", 128'(bus.memWriteEnabled), 128'(0));
        check("rst_mid_addr", 128'(bus.memAddress), 128'(0));
        check("rst_mid_wdata", 128'(bus.memDataWrite), 128'(0));
        check("rst_mid_acks", 128'({bus.ack0, bus.ack1}), 128'(0));
        check("rst_mid_dataRead", 128'(bus.dataRead), 128'(0));
        check("rst_mid_accessError", 128'(bus.accessError), 128'(0));
        bus.req0 = 1'b0; bus.writeEnabled0 = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_mem_unchanged", 128'(mem[16]), 128'(32'hA000_0010));
        resetN = 1'b1;
        @(negedge clock);
        run_access(0, 1'b0, 32'h40, 32'h0, 32'hA000_0010, 1'b0, 2, "post_reset_load");
        repeat (2) @(negedge clock);

        check("q0_drained", 128'(q0.size()), 128'(0));
        check("q1_drained", 128'(q1.size()), 128'(0));
        check("oor_write_cycles", 128'(oor_writes), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
